rr_grant_arbiter: RTL and testbench
===================================

# rr_grant_arbiter

Four-way round-robin arbiter that turns raw, possibly multi-hot request lines into a registered one-hot grant vector. It sits directly upstream of the 4-to-2 one-hot encoder, so the encoder only ever sees 4'b0000 or a single set bit and never an ambiguous input. Each grant is held until the owner releases it, its request drops, or a programmable timeout expires. The grant pointer then rotates so that no requester starves.

## Interface
- TIMEOUT, default 15: maximum consecutive cycles a single grant may be held; range 1..255; 0 disables the timeout.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request lines; bit i = requester i; any combination legal
- done  input  1  release strobe from the current grant owner; sampled only while a grant is active
- grant  output  4  registered one-hot grant, or 4'b0000; feeds the encoder input
- gnt_valid  output  1  registered; equals |grant
- tmo  output  1  registered one-cycle pulse; grant was revoked by timeout

## Operation
- State machine: IDLE, GRANT.
- Internal state:
  - ptr[1:0]: highest-priority index for the next arbitration.
  - cnt[7:0]: number of cycles the current grant has been held.
  - owner[1:0]: index of the current grant owner.
- IDLE:
  - If req == 0, stay in IDLE with grant = 0.
  - Otherwise search req starting at ptr, wrapping through ptr+1, ptr+2, ptr+3 (mod 4). The first set bit i becomes the owner.
  - Next state: GRANT, with grant = 1<<i, cnt = 1, owner = i.
- GRANT, release conditions evaluated every cycle:
  - (a) done == 1.
  - (b) req[owner] == 0.
  - (c) TIMEOUT != 0 and cnt == TIMEOUT.
- On release: next state IDLE, grant = 0, ptr = owner+1 (mod 4, so 3 wraps to 0), cnt = 0.
- tmo = 1 for exactly the release cycle, and only when (c) is the sole cause. If (a) or (b) coincides with (c), tmo stays 0.
- No release: grant holds and cnt increments. cnt saturates at 255 when TIMEOUT = 0.
- Changes on req bits other than req[owner] during GRANT are ignored.
- A release is always followed by at least one IDLE cycle with grant = 0, even if requests remain pending. This guarantees that a registered grant never switches directly from one owner to another.
- Invariant: $countones(grant) <= 1 at all times.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately even mid-grant):
  - grant = 4'b0000, gnt_valid = 0, tmo = 0.
  - State IDLE, ptr = 0, cnt = 0, owner = 0.
- The first rising edge after rst_n deasserts may arbitrate.
- Request-to-grant latency: req sampled high at edge k gives grant valid after edge k, i.e. 1 cycle.
- Release latency: done or a req drop sampled at edge k clears grant after edge k.
- With TIMEOUT = T, grant is high for exactly T cycles, and tmo is high in the cycle immediately after the last grant cycle.
- Minimum grant period: 1 cycle (done asserted on the first grant cycle).
- Back-to-back service: requests held continuously give grant-active, idle, grant-active, ... Each requester waits at most 3 grant periods plus 4 idle cycles.

## Test plan
- Reset, then req = 4'b1111 held with done pulsed on each grant's first cycle:
  - grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - gnt_valid tracks grant throughout.
- Pointer wrap:
  - req = 4'b1000 granted and released, then req = 4'b1001 -> grant 0001 (ptr wrapped to 0).
  - Then req = 4'b1001 again -> grant 1000.
- TIMEOUT = 3, req = 4'b0100 held, done = 0:
  - grant = 0100 for exactly 3 cycles, then 0000 with tmo = 1 for one cycle.
  - Next: grant = 0100 again, since it is the only requester.
- Simultaneous events and reset:
  - With TIMEOUT = 3, done asserted in the 3rd grant cycle -> release with tmo = 0.
  - Asserting rst_n low mid-grant (grant = 0010) -> grant = 0000 immediately, before the next clock edge.
  - After reset, req = 4'b0110 -> grant 0010 (ptr reset to 0).
- Request drop and multi-hot: grant = 0001, then req changes 4'b0011 -> 4'b0010:
  - grant 0000 for one cycle, then grant 0010.
  - Throughout, grant is never multi-hot, and the downstream encoder output follows 00, 00, 01.
- TIMEOUT = 0, req = 4'b0001 held for 300 cycles:
  - grant stays 0001 and tmo never asserts (cnt saturates at 255).

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter producing a registered one-hot grant.
// Grants are held until done, request drop or timeout, then rotate past the owner.
module rr_grant_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       gnt_valid,
    output logic       tmo
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    localparam bit         TMO_EN    = (TIMEOUT != 0);
    localparam logic [7:0] CNT_MAX   = 8'hFF;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] grant_q, grant_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       tmo_q, tmo_d;

    logic       found;
    logic [1:0] sel;
    logic [1:0] cand;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_tmo;
    logic       release_now;

    // Search starts at ptr and wraps, so the last owner has lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        rel_done    = done;
        rel_drop    = ~req[owner_q];
        rel_tmo     = TMO_EN && (cnt_q == TMO_LIMIT);
        release_now = rel_done || rel_drop || rel_tmo;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        grant_d = grant_q;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                cnt_d   = 8'd0;
                if (found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << sel;
                    cnt_d   = 8'd1;
                    owner_d = sel;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Always drop to IDLE first so the grant never hops owners in one edge.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    cnt_d   = 8'd0;
                    tmo_d   = rel_tmo && !rel_done && !rel_drop;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase

        gnt_valid_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 8'd0;
            owner_q     <= 2'd0;
            grant_q     <= 4'b0000;
            gnt_valid_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            gnt_valid_q <= gnt_valid_d;
            tmo_q       <= tmo_d;
        end
    end

    assign grant     = grant_q;
    assign gnt_valid = gnt_valid_q;
    assign tmo       = tmo_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter with TIMEOUT = 15, 3 and 0 instances.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req0, req1, req2;
    logic       done0, done1, done2;
    logic [3:0] grant0, grant1, grant2;
    logic       gv0, gv1, gv2;
    logic       tmo0, tmo1, tmo2;

    int n_asserts;
    int n_fail;

    logic [3:0] sb_grant[$];
    logic       sb_tmo[$];
    int         sb_sel[$];
    string      sb_tag[$];

    rr_grant_arbiter #(.TIMEOUT(15)) dut_t15 (
        .clk(clk), .rst_n(rst_n), .req(req0), .done(done0),
        .grant(grant0), .gnt_valid(gv0), .tmo(tmo0)
    );

    rr_grant_arbiter #(.TIMEOUT(3)) dut_t3 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
        .grant(grant1), .gnt_valid(gv1), .tmo(tmo1)
    );

    rr_grant_arbiter #(.TIMEOUT(0)) dut_t0 (
        .clk(clk), .rst_n(rst_n), .req(req2), .done(done2),
        .grant(grant2), .gnt_valid(gv2), .tmo(tmo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation and compares it against the selected instance.
    task automatic checkOutput();
        logic [3:0] eg, og;
        logic       et, ogv, ot;
        int         s;
        string      tag;
        eg  = sb_grant.pop_front();
        et  = sb_tmo.pop_front();
        s   = sb_sel.pop_front();
        tag = sb_tag.pop_front();
        case (s)
            0:       begin og = grant0; ogv = gv0; ot = tmo0; end
            1:       begin og = grant1; ogv = gv1; ot = tmo1; end
            default: begin og = grant2; ogv = gv2; ot = tmo2; end
        endcase
        checkValue({tag, " grant"}, og, eg);
        checkValue({tag, " gnt_valid"}, {3'b000, ogv}, {3'b000, |eg});
        checkValue({tag, " tmo"}, {3'b000, ot}, {3'b000, et});
        checkValue({tag, " onehot"}, {3'b000, ($countones(og) <= 1)}, 4'b0001);
    endtask

    // Drives one cycle of inputs, records the expected post-edge outputs, then checks them.
    task automatic applyStimulus(input int s, input logic [3:0] r, input logic d,
                                 input logic [3:0] eg, input logic et, input string tag);
        case (s)
            0:       begin req0 = r; done0 = d; end
            1:       begin req1 = r; done1 = d; end
            default: begin req2 = r; done2 = d; end
        endcase
        sb_grant.push_back(eg);
        sb_tmo.push_back(et);
        sb_sel.push_back(s);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst_n = 1'b0;
        req0 = 4'b0; req1 = 4'b0; req2 = 4'b0;
        done0 = 1'b0; done1 = 1'b0; done2 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkValue("reset grant0", grant0, 4'b0000);
        checkValue("reset gv0", {3'b0, gv0}, 4'b0000);
        checkValue("reset tmo0", {3'b0, tmo0}, 4'b0000);
        checkValue("reset grant1", grant1, 4'b0000);
        checkValue("reset grant2", grant2, 4'b0000);
        rst_n = 1'b1;

        // Full rotation with done pulsed on each grant's first cycle.
        applyStimulus(0, 4'b1111, 1'b0, 4'b0001, 1'b0, "rot g0");
        applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot i0");
        applyStimulus(0, 4'b1111, 1'b0, 4'b0010, 1'b0, "rot g1");
        applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot i1");
        applyStimulus(0, 4'b1111, 1'b0, 4'b0100, 1'b0, "rot g2");
        applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot i2");
        applyStimulus(0, 4'b1111, 1'b0, 4'b1000, 1'b0, "rot g3");
        applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot i3");
        applyStimulus(0, 4'b1111, 1'b0, 4'b0001, 1'b0, "rot g0b");
        applyStimulus(0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rot i0b");
        applyStimulus(0, 4'b0000, 1'b0, 4'b0000, 1'b0, "rot idle");

        // Pointer wrap from requester 3 back to 0.
        applyStimulus(0, 4'b1000, 1'b0, 4'b1000, 1'b0, "wrap g3");
        applyStimulus(0, 4'b1000, 1'b1, 4'b0000, 1'b0, "wrap rel3");
        applyStimulus(0, 4'b1001, 1'b0, 4'b0001, 1'b0, "wrap g0");
        applyStimulus(0, 4'b1001, 1'b1, 4'b0000, 1'b0, "wrap rel0");
        applyStimulus(0, 4'b1001, 1'b0, 4'b1000, 1'b0, "wrap g3b");
        applyStimulus(0, 4'b0000, 1'b0, 4'b0000, 1'b0, "wrap drop");

        // Request drop with multi-hot requests.
        applyStimulus(0, 4'b0011, 1'b0, 4'b0001, 1'b0, "drop g0");
        applyStimulus(0, 4'b0010, 1'b0, 4'b0000, 1'b0, "drop rel");
        applyStimulus(0, 4'b0010, 1'b0, 4'b0010, 1'b0, "drop g1");
        applyStimulus(0, 4'b0000, 1'b0, 4'b0000, 1'b0, "drop idle");

        // Asynchronous reset mid-grant, then ptr restarts at 0.
        applyStimulus(0, 4'b0010, 1'b0, 4'b0010, 1'b0, "arst g1");
        rst_n = 1'b0;
        #2;
        checkValue("arst grant", grant0, 4'b0000);
        checkValue("arst gv", {3'b0, gv0}, 4'b0000);
        req0 = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 4'b0110, 1'b0, 4'b0010, 1'b0, "arst ptr0");
        applyStimulus(0, 4'b0000, 1'b0, 4'b0000, 1'b0, "arst idle");

        // TIMEOUT = 3: exactly three grant cycles then a tmo pulse.
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo c1");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo c2");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo c3");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0000, 1'b1, "tmo rel");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo regrant");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo rc2");
        applyStimulus(1, 4'b0100, 1'b0, 4'b0100, 1'b0, "tmo rc3");
        applyStimulus(1, 4'b0100, 1'b1, 4'b0000, 1'b0, "tmo done+to");
        applyStimulus(1, 4'b0000, 1'b0, 4'b0000, 1'b0, "tmo idle");

        // TIMEOUT = 0: grant held well past counter saturation.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(2, 4'b0001, 1'b0, 4'b0001, 1'b0, $sformatf("t0 hold %0d", i));
        end
        applyStimulus(2, 4'b0000, 1'b0, 4'b0000, 1'b0, "t0 drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
